// File: rtl/prog_mem_ctrl_pkg.sv
// Shared definitions for the loadable program memory: controller states,
// read-data source select, default fill word and ISA opcodes.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } pm_state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_HALT
    } rd_sel_t;

    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hF000;

    // Opcodes live in the top 4 bits of an instruction; the CPU decoder uses these too.
    localparam logic [3:0] OP_MOV  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_RL   = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    function automatic logic [3:0] opcodeOf(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// Fetch port and streaming load port of the program memory, bundled
// so that the CPU/host side and the memory side share one definition.
interface prog_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    logic              rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rom_valid;
    logic              rom_err;
    logic              busy;
    logic              ld_start;
    logic              ld_end;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              ld_full;

    modport slave (
        input  rd, rom_addr, ld_start, ld_end, ld_valid, ld_data,
        output rom_data, rom_valid, rom_err, busy, ld_ready, ld_count, ld_full
    );

    modport master (
        output rd, rom_addr, ld_start, ld_end, ld_valid, ld_data,
        input  rom_data, rom_valid, rom_err, busy, ld_ready, ld_count, ld_full
    );
endinterface

// File: rtl/prog_mem_ctrl_mem_array_sp.sv
// Single-port synchronous RAM; read data is captured only when i_re is set
// so it holds across cycles where the port is busy writing or idle.
module mem_array_sp #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/prog_mem_ctrl.sv
// Loadable program memory: clears to HALT after reset, accepts a streamed
// program in LOAD, and serves 1-cycle fetches in RUN.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
    input logic            clk,
    input logic            rst,
    prog_mem_ctrl_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    pm_state_t       r_state;
    rd_sel_t         r_romSel;
    logic [ADDR_W:0] r_ptr;
    logic [ADDR_W:0] r_ldCount;
    logic            r_romValid;
    logic            r_romErr;
    logic            r_busy;

    logic              w_fetchInRange;
    logic              w_ldReady;
    logic              w_ldAccept;
    logic              w_we;
    logic              w_re;
    logic [IDX_W-1:0]  w_ramAddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ramRdata;
    logic [DATA_W-1:0] w_romData;

    assign w_fetchInRange = {1'b0, bus.rom_addr} < DEPTH_L;
    assign w_ldReady      = (r_state == LOAD) && (r_ldCount < DEPTH_L);
    assign w_ldAccept     = w_ldReady && bus.ld_valid && !bus.ld_start;

    // The single RAM port is shared: CLEAR and LOAD write, RUN reads.
    assign w_we    = !rst && ((r_state == CLEAR) || w_ldAccept);
    assign w_re    = !rst && (r_state == RUN) && bus.rd && w_fetchInRange;
    assign w_wdata = (r_state == CLEAR) ? HALT_WORD : bus.ld_data;

    always_comb begin
        w_ramAddr = bus.rom_addr[IDX_W-1:0];
        case (r_state)
            CLEAR:   w_ramAddr = r_ptr[IDX_W-1:0];
            LOAD:    w_ramAddr = r_ldCount[IDX_W-1:0];
            default: w_ramAddr = bus.rom_addr[IDX_W-1:0];
        endcase
    end

    mem_array_sp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_ramAddr),
        .i_wdata (w_wdata),
        .o_rdata (w_ramRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_ptr      <= '0;
            r_ldCount  <= '0;
            r_romValid <= 1'b0;
            r_romErr   <= 1'b0;
            r_romSel   <= SEL_ZERO;
            r_busy     <= 1'b1;
        end else begin
            r_romValid <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == DEPTH_L - 1'b1) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.rd) begin
                        r_romValid <= 1'b1;
                        r_romErr   <= !w_fetchInRange;
                        r_romSel   <= w_fetchInRange ? SEL_RAM : SEL_HALT;
                    end
                    if (bus.ld_start) begin
                        r_state   <= LOAD;
                        r_ldCount <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart wins over both an incoming word and ld_end.
                    if (bus.ld_start) begin
                        r_ldCount <= '0;
                    end else begin
                        if (w_ldAccept) begin
                            r_ldCount <= r_ldCount + 1'b1;
                        end
                        if (bus.ld_end) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_romData = '0;
        case (r_romSel)
            SEL_RAM:  w_romData = w_ramRdata;
            SEL_HALT: w_romData = HALT_WORD;
            default:  w_romData = '0;
        endcase
    end

    assign bus.rom_data  = w_romData;
    assign bus.rom_valid = r_romValid;
    assign bus.rom_err   = r_romErr;
    assign bus.busy      = r_busy;
    assign bus.ld_ready  = w_ldReady;
    assign bus.ld_count  = r_ldCount;
    assign bus.ld_full   = (r_ldCount == DEPTH_L);
endmodule

// File: doc/prog_mem_ctrl.md
Name: prog_mem_ctrl

Overview:
- Parametrised, loadable program memory for the simple processor. Replaces the fixed, reset-initialised instruction ROM.
- After reset, a clear sequencer fills every word with HALT_WORD.
- A host-side streaming load port then writes a program. The load port uses auto-increment addressing with a valid/ready handshake.
- The CPU fetches through a 1-cycle-latency read port with a valid strobe and an out-of-range flag.

Parameters:
- DATA_W, 16: instruction width; the opcode is in the top 4 bits.
- ADDR_W, 8: fetch/load address width.
- DEPTH, 2**ADDR_W: number of implemented words; must be at most 2**ADDR_W.
- HALT_WORD, 16'hF000: fill value written by the clear sequencer and returned on an out-of-range fetch.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rd  in  1  fetch request.
- rom_addr  in  ADDR_W  fetch address.
- rom_data  out  DATA_W  fetched word.
- rom_valid  out  1  rom_data updated this cycle.
- rom_err  out  1  last fetch was out of range (rom_addr >= DEPTH).
- busy  out  1  block is in CLEAR or LOAD; fetches are ignored.
- ld_start  in  1  enter LOAD and reset the write pointer.
- ld_end  in  1  leave LOAD and return to RUN.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  program word.
- ld_ready  out  1  block can accept a word.
- ld_count  out  ADDR_W+1  words written in the current load.
- ld_full  out  1  write pointer has reached DEPTH.

Behaviour:
- Reset, sampled on the clk edge with rst=1:
  - State = CLEAR, clear pointer = 0.
  - rom_data=0, rom_valid=0, rom_err=0, busy=1, ld_ready=0, ld_count=0, ld_full=0.
  - Reset asserted mid-LOAD or mid-CLEAR aborts the operation and restarts CLEAR.
- CLEAR:
  - Writes HALT_WORD to address ptr each cycle, then ptr++.
  - After the write to DEPTH-1, the next state is RUN.
  - Takes exactly DEPTH cycles, so busy falls DEPTH cycles after the first cycle with rst=0.
  - Load inputs are ignored during CLEAR.
- RUN, fetch:
  - rd=1 with rom_addr < DEPTH: on the next edge, rom_data=mem[rom_addr], rom_valid=1, rom_err=0.
  - rd=1 with rom_addr >= DEPTH: rom_data=HALT_WORD, rom_valid=1, rom_err=1.
  - rd=0: rom_valid=0; rom_data and rom_err hold their values.
  - Latency is 1 cycle. Back-to-back fetches are allowed every cycle.
- RUN to LOAD:
  - ld_start=1 moves to LOAD with ptr=0, ld_count=0, ld_full=0.
  - An rd in that same cycle is still serviced.
- LOAD:
  - ld_ready = (ptr < DEPTH).
  - On ld_valid && ld_ready: mem[ptr] <= ld_data, ptr++, ld_count++.
  - ld_full=1 once ptr==DEPTH. Further ld_valid is not accepted (ld_ready=0) and the word is dropped.
  - ld_start in LOAD restarts with ptr=0, ld_count=0. ld_start has priority over ld_end.
  - ld_end with a valid word in the same cycle: the word is written first, then the state moves to RUN.
  - Words not rewritten keep their previous contents (HALT_WORD or an earlier program).
  - rd is ignored in LOAD: rom_valid=0.
  - ld_count holds its value after ld_end until the next ld_start or reset.
- busy = (state != RUN); it is a registered output.
- Storage is a single-port synchronous RAM. Only one access happens per cycle: write in CLEAR/LOAD, read in RUN.

Decomposition:
- prog_mem_pkg holds:
  - the state enum {CLEAR, LOAD, RUN};
  - the default HALT_WORD;
  - the ISA opcode constants (MOV imm 4'b0011, ADD 4'b0100, SUB 4'b0101, JZ 4'b0110, RL 4'b0111, HALT 4'b1111), shared with the CPU decoder.
- Sub-module mem_array_sp: a parametrised single-port synchronous RAM (we, addr, wdata, rdata), with no reset on the array.

Test Plan (DEPTH=16, ADDR_W=8 unless stated):
- Clear: release rst, count cycles -> busy=1 for exactly 16 cycles. Afterwards, fetches of addresses 0..15 return 16'hF000 with rom_valid=1 and rom_err=0.
- Load and fetch:
  - Stimulus: ld_start, then stream the 12-word sum program (first word 16'h3000, last word 16'hF00B), then ld_end.
  - Response: ld_count=12; rd at addr 0 -> 16'h3000 one cycle later; addr 11 -> 16'hF00B; addr 12 -> 16'hF000.
- Backpressure: stream 20 words with ld_valid held high -> ld_ready drops after the 16th word, ld_full=1, ld_count=16, and word 17 is not written (addr 0 is unchanged).
- Range error: rd at addr 8'd20 -> rom_data=16'hF000, rom_err=1. A subsequent rd at addr 3 clears rom_err.
- Priorities:
  - ld_end together with ld_valid carrying 16'h1234 at ptr 5 -> mem[5]=16'h1234, then RUN.
  - ld_start together with ld_end in LOAD -> stays in LOAD with ld_count=0.
  - rd during LOAD -> rom_valid=0.
- Reset mid-load: assert rst after 4 loaded words -> state is CLEAR, busy=1, ld_count=0, and after 16 cycles all words read 16'hF000.
